// File: rtl/aes256_cbc_framer_if.sv
// Byte-stream handshake bundle shared by the framer's payload input and core-facing output.
interface axis_if #(
  parameter int W = 8
);
  logic         tvalid;
  logic         tready;
  logic [W-1:0] tdata;
  logic         tlast;
  logic         tkeep;
  logic         tuser;

  modport master (output tvalid, tdata, tlast, tkeep, tuser, input tready);
  modport slave  (input tvalid, tdata, tlast, tkeep, tuser, output tready);
endinterface

// File: rtl/aes256_cbc_framer.sv
// Frames one message for the AES-256-CBC core: key word 0, key word 1, IV, then payload
// blocks, padded (PKCS#7) when encrypting and alignment-checked when decrypting.
module aes256_cbc_framer #(
  parameter int BLOCK_BYTES = 16,
  parameter int AXIS_WIDTH  = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_cfg_valid,
  output logic         o_cfg_ready,
  input  logic [255:0] i_cfg_key,
  input  logic [127:0] i_cfg_iv,
  input  logic         i_cfg_enc,
  axis_if.slave        s_axis,
  axis_if.master       m_axis,
  output logic         o_err
);

  localparam int             CW      = $clog2(BLOCK_BYTES);
  localparam logic [CW-1:0]  CNT_TOP = CW'(BLOCK_BYTES - 1);
  localparam logic [CW:0]    PAD_FULL = (CW+1)'(BLOCK_BYTES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_KEY_0,
    ST_KEY_1,
    ST_IV,
    ST_DATA,
    ST_PAD
  } state_t;

  typedef struct packed {
    logic [255:0] key;
    logic [127:0] iv;
    logic         enc;
  } cfg_t;

  state_t                r_state, w_next;
  cfg_t                  r_cfg;
  logic [CW-1:0]         r_byte_cnt;
  logic [CW:0]           r_pad_val;

  logic                  w_m_valid;
  logic [AXIS_WIDTH-1:0] w_m_data;
  logic                  w_m_last;
  logic                  w_s_ready;
  logic                  w_cfg_ready;
  logic                  w_err;
  logic                  w_cnt_adv;
  logic                  w_s_hs;
  logic                  w_at_top;
  logic [CW+2:0]         w_idx;
  logic                  w_unused;

  assign w_at_top = (r_byte_cnt == CNT_TOP);
  assign w_idx    = {r_byte_cnt, 3'b000};
  assign w_s_hs   = s_axis.tvalid && w_s_ready;
  assign w_unused = ^{s_axis.tkeep, s_axis.tuser};

  always_comb begin
    w_next      = r_state;
    w_m_valid   = 1'b0;
    w_m_data    = '0;
    w_m_last    = 1'b0;
    w_s_ready   = 1'b0;
    w_cfg_ready = 1'b0;
    w_err       = 1'b0;
    w_cnt_adv   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_cfg_ready = 1'b1;
        if (i_cfg_valid) w_next = ST_KEY_0;
      end
      ST_KEY_0: begin
        w_m_valid = 1'b1;
        w_m_data  = r_cfg.key[w_idx +: 8];
        w_cnt_adv = m_axis.tready;
        if (m_axis.tready && w_at_top) w_next = ST_KEY_1;
      end
      ST_KEY_1: begin
        w_m_valid = 1'b1;
        w_m_data  = r_cfg.key[{1'b1, w_idx} +: 8];
        w_cnt_adv = m_axis.tready;
        if (m_axis.tready && w_at_top) w_next = ST_IV;
      end
      ST_IV: begin
        w_m_valid = 1'b1;
        w_m_data  = r_cfg.iv[w_idx +: 8];
        w_cnt_adv = m_axis.tready;
        if (m_axis.tready && w_at_top) w_next = ST_DATA;
      end
      ST_DATA: begin
        // Pure wire path: the core sees payload bytes in the same cycle they arrive.
        w_m_valid = s_axis.tvalid;
        w_m_data  = s_axis.tdata;
        w_s_ready = m_axis.tready;
        w_m_last  = s_axis.tlast && !r_cfg.enc && w_at_top;
        w_cnt_adv = w_s_hs;
        if (w_s_hs && s_axis.tlast) begin
          if (r_cfg.enc) begin
            w_next = ST_PAD;
          end else if (w_at_top) begin
            w_next = ST_IDLE;
          end else begin
            w_err  = 1'b1;
            w_next = ST_PAD;
          end
        end
      end
      ST_PAD: begin
        w_m_valid = 1'b1;
        w_m_data  = AXIS_WIDTH'(r_pad_val);
        w_m_last  = w_at_top;
        w_cnt_adv = m_axis.tready;
        if (m_axis.tready && w_at_top) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_cfg      <= '0;
      r_byte_cnt <= '0;
      r_pad_val  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == ST_IDLE && i_cfg_valid) begin
        r_cfg      <= '{key: i_cfg_key, iv: i_cfg_iv, enc: i_cfg_enc};
        r_byte_cnt <= '0;
      end else if (w_cnt_adv) begin
        r_byte_cnt <= r_byte_cnt + 1'b1;
      end
      // A full final block still gets a whole block of padding when encrypting.
      if (r_state == ST_DATA && w_s_hs && s_axis.tlast) begin
        if (!r_cfg.enc)    r_pad_val <= '0;
        else if (w_at_top) r_pad_val <= PAD_FULL;
        else               r_pad_val <= (CW+1)'(BLOCK_BYTES - 1) - {1'b0, r_byte_cnt};
      end
    end
  end

  assign o_cfg_ready   = w_cfg_ready && i_rst_n;
  assign o_err         = w_err;
  assign s_axis.tready = w_s_ready;
  assign m_axis.tvalid = w_m_valid;
  assign m_axis.tdata  = w_m_data;
  assign m_axis.tlast  = w_m_last;
  assign m_axis.tkeep  = w_m_valid;
  assign m_axis.tuser  = (r_state != ST_IDLE) && r_cfg.enc;

endmodule

// File: tb/tb_aes256_cbc_framer.sv
// Scoreboard bench: the driver queues the expected framed bytes per message, a monitor
// pops and compares on every output handshake.
module tb_aes256_cbc_framer;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         cfg_valid = 1'b0;
  logic         cfg_ready;
  logic [255:0] cfg_key = '0;
  logic [127:0] cfg_iv = '0;
  logic         cfg_enc = 1'b0;
  logic         err;

  always #5 clk = ~clk;

  axis_if #(.W(8)) s_if ();
  axis_if #(.W(8)) m_if ();

  aes256_cbc_framer dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_cfg_valid (cfg_valid),
    .o_cfg_ready (cfg_ready),
    .i_cfg_key   (cfg_key),
    .i_cfg_iv    (cfg_iv),
    .i_cfg_enc   (cfg_enc),
    .s_axis      (s_if),
    .m_axis      (m_if),
    .o_err       (err)
  );

  typedef struct {
    logic [7:0] d;
    logic       l;
    logic       u;
  } beat_t;

  beat_t exp_q[$];
  int    n_tests = 0;
  int    n_fail = 0;
  int    err_exp = 0;
  int    err_seen = 0;
  bit    rdy_rand = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Sink backpressure
  initial begin
    m_if.tready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      m_if.tready = rdy_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
  end

  // Monitor / scoreboard
  initial begin : mon
    bit    stall;
    beat_t sb;
    beat_t e;
    stall = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        stall = 1'b0;
        continue;
      end
      if (stall) begin
        chk("stall_valid", 64'(m_if.tvalid), 64'd1);
        chk("stall_hold", 64'({m_if.tdata, m_if.tlast, m_if.tuser}), 64'({sb.d, sb.l, sb.u}));
      end
      if (m_if.tvalid && m_if.tready) begin
        stall = 1'b0;
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_beat: got data 0x%0h with no expected beat", m_if.tdata);
        end else begin
          e = exp_q.pop_front();
          chk("m_tdata", 64'(m_if.tdata), 64'(e.d));
          chk("m_tlast", 64'(m_if.tlast), 64'(e.l));
          chk("m_tuser", 64'(m_if.tuser), 64'(e.u));
          chk("m_tkeep", 64'(m_if.tkeep), 64'd1);
        end
      end else if (m_if.tvalid) begin
        stall = 1'b1;
        sb = '{m_if.tdata, m_if.tlast, m_if.tuser};
      end else begin
        stall = 1'b0;
      end
      if (err) begin
        err_seen++;
        chk("err_on_last_hs", 64'(s_if.tvalid && s_if.tready && s_if.tlast), 64'd1);
      end
    end
  end

  task automatic send_msg(input logic [255:0] key, input logic [127:0] iv, input bit enc,
                          input logic [7:0] pl[$], input bit poke, input bit rst_pad);
    int    n;
    int    p;
    bit    acc;
    bit    hs;
    beat_t b;
    n = pl.size();
    for (int i = 0; i < 32; i++) exp_q.push_back('{key[8*i +: 8], 1'b0, enc});
    for (int i = 0; i < 16; i++) exp_q.push_back('{iv[8*i +: 8], 1'b0, enc});
    for (int i = 0; i < n; i++) exp_q.push_back('{pl[i], 1'b0, enc});
    if (enc) begin
      p = 16 - (n % 16);
      for (int i = 0; i < p; i++) exp_q.push_back('{8'(p), 1'b0, enc});
    end else begin
      p = (16 - (n % 16)) % 16;
      if (p != 0) err_exp++;
      for (int i = 0; i < p; i++) exp_q.push_back('{8'h00, 1'b0, enc});
    end
    b = exp_q.pop_back();
    b.l = 1'b1;
    exp_q.push_back(b);

    cfg_key = key;
    cfg_iv = iv;
    cfg_enc = enc;
    cfg_valid = 1'b1;
    acc = 1'b0;
    for (int k = 0; k < 200 && !acc; k++) begin
      @(negedge clk);
      acc = cfg_ready;
      @(posedge clk);
      #1;
    end
    cfg_valid = 1'b0;
    chk("cfg_accept", 64'(acc), 64'd1);
    if (!acc) return;
    @(negedge clk);
    chk("first_beat_latency", 64'(m_if.tvalid), 64'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < n; i++) begin
      if (poke && i < n - 1 && $urandom_range(0, 2) == 0) begin
        cfg_valid = 1'b1;
        cfg_key = ~key;
        cfg_enc = ~enc;
        @(negedge clk);
        chk("cfg_ready_busy", 64'(cfg_ready), 64'd0);
        @(posedge clk);
        #1;
        cfg_valid = 1'b0;
      end
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
      s_if.tvalid = 1'b1;
      s_if.tdata = pl[i];
      s_if.tlast = (i == n - 1);
      s_if.tuser = 1'($urandom);
      s_if.tkeep = 1'b1;
      hs = 1'b0;
      for (int k = 0; k < 2000 && !hs; k++) begin
        @(negedge clk);
        hs = s_if.tready;
        @(posedge clk);
        #1;
      end
      s_if.tvalid = 1'b0;
      s_if.tlast = 1'b0;
      chk("s_handshake", 64'(hs), 64'd1);
      if (!hs) begin
        exp_q.delete();
        return;
      end
    end

    if (rst_pad) begin
      #1;
      rst_n = 1'b0;
      #1;
      chk("rst_m_tvalid", 64'(m_if.tvalid), 64'd0);
      chk("rst_m_tdata", 64'(m_if.tdata), 64'd0);
      chk("rst_m_tlast", 64'(m_if.tlast), 64'd0);
      chk("rst_m_tuser", 64'(m_if.tuser), 64'd0);
      chk("rst_s_tready", 64'(s_if.tready), 64'd0);
      chk("rst_cfg_ready", 64'(cfg_ready), 64'd0);
      chk("rst_err", 64'(err), 64'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_cfg_ready", 64'(cfg_ready), 64'd1);
      @(posedge clk);
      #1;
      return;
    end

    for (int k = 0; k < 3000 && exp_q.size() != 0; k++) @(posedge clk);
    #1;
    chk("drain", 64'(exp_q.size()), 64'd0);
    exp_q.delete();
  endtask

  initial begin
    logic [255:0] kp;
    logic [127:0] ivp;
    logic [7:0]   pl[$];
    int           len;

    for (int i = 0; i < 32; i++) kp[8*i +: 8] = 8'(i);
    for (int i = 0; i < 16; i++) ivp[8*i +: 8] = 8'(8'hF0 + i);
    s_if.tvalid = 1'b0;
    s_if.tdata = '0;
    s_if.tlast = 1'b0;
    s_if.tkeep = 1'b0;
    s_if.tuser = 1'b0;

    #12;
    chk("reset_cfg_ready", 64'(cfg_ready), 64'd0);
    chk("reset_m_tvalid", 64'(m_if.tvalid), 64'd0);
    chk("reset_s_tready", 64'(s_if.tready), 64'd0);
    chk("reset_err", 64'(err), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cfg_ready", 64'(cfg_ready), 64'd1);
    @(posedge clk);
    #1;

    pl.delete();
    for (int i = 0; i < 16; i++) pl.push_back(8'(i));
    send_msg(kp, ivp, 1'b1, pl, 1'b0, 1'b0);

    pl.delete();
    for (int i = 0; i < 5; i++) pl.push_back(8'(8'hA1 + i));
    send_msg(kp, ivp, 1'b1, pl, 1'b0, 1'b0);

    pl.delete();
    for (int i = 0; i < 32; i++) pl.push_back(8'($urandom));
    send_msg({$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom},
             {$urandom, $urandom, $urandom, $urandom}, 1'b0, pl, 1'b0, 1'b0);

    pl.delete();
    for (int i = 0; i < 20; i++) pl.push_back(8'($urandom));
    send_msg(kp, ivp, 1'b0, pl, 1'b0, 1'b0);

    rdy_rand = 1'b1;
    for (int m = 0; m < 8; m++) begin
      pl.delete();
      len = $urandom_range(1, 40);
      for (int i = 0; i < len; i++) pl.push_back(8'($urandom));
      send_msg(kp, ivp, 1'($urandom), pl, 1'b1, 1'b0);
    end

    pl.delete();
    pl.push_back(8'h3C);
    send_msg(kp, ivp, 1'b1, pl, 1'b0, 1'b1);
    pl.delete();
    pl.push_back(8'($urandom));
    send_msg(kp, ivp, 1'b1, pl, 1'b0, 1'b0);

    repeat (4) @(posedge clk);
    chk("err_pulse_count", 64'(err_seen), 64'(err_exp));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/aes256_cbc_framer.md
Name: aes256_cbc_framer

Overview:
- Upstream framing stage for the iterative AES-256-CBC core.
- Takes a per-message configuration (256-bit key, 128-bit IV, direction) and a byte-wide payload stream with tlast. Emits the exact byte sequence the core consumes: key low half, key high half, IV, then text blocks.
- On encryption, applies PKCS#7 padding so the core only ever sees whole 16-byte blocks. On decryption, enforces block alignment.

Parameters:
- BLOCK_BYTES, 16, AES block size in bytes; fixed, not to be overridden.
- AXIS_WIDTH, 8, S_axis/M_axis tdata width in bits; only 8 is supported.

Ports:
- Clk  input  1  clock; all logic on rising edge.
- Rst_n  input  1  reset; asynchronous assert, active-low.
- Cfg_valid  input  1  configuration for the next message is valid.
- Cfg_ready  output  1  framer can accept a configuration.
- Cfg_key  input  256  AES-256 key. Bits [127:0] are key word 0; bits [255:128] are key word 1.
- Cfg_iv  input  128  CBC initialisation vector.
- Cfg_enc  input  1  1 = encrypt (pad), 0 = decrypt (no pad).
- S_axis  axis_if.slave  8-bit  payload bytes. tlast marks the final payload byte; tuser is ignored.
- M_axis  axis_if.master  8-bit  framed stream to the core. tkeep is always 1 when valid; tuser equals the latched enc flag on every beat.
- Err  output  1  one-cycle pulse when a decrypt message ends misaligned.

Behaviour:
- Reset (Rst_n low, any time, including mid-message):
  - state goes to ST_IDLE; all counters and latched configuration clear.
  - M_axis tvalid, tdata, tlast and tuser are 0; S_axis tready is 0; Cfg_ready is 0 while in reset.
  - Err is 0.
- States:
  - ST_IDLE: Cfg_ready=1. When Cfg_valid=1, latch key, IV and enc, then go to ST_KEY_0.
  - ST_KEY_0, ST_KEY_1, ST_IV: each emits 16 bytes, LSB byte first. Byte i is bits [8i+7:8i] of key word 0, key word 1 and IV respectively.
    - byte_cnt (4-bit) advances on each M handshake.
    - Wrap from 15 to 0 moves to the next state; ST_IV moves to ST_DATA.
    - S_axis tready=0 in these states.
  - ST_DATA: combinational pass-through.
    - M tvalid=S tvalid, M tdata=S tdata, S tready=M tready.
    - byte_cnt advances on each handshake and wraps modulo 16.
    - Zero added latency; no buffering.
  - ST_DATA on a handshake with S tlast=1, using n = byte_cnt+1 (1..16):
    - enc=1: M tlast=0 on this beat. Set pad_val = 16 - (n mod 16), giving 16 when n=16. Go to ST_PAD.
    - enc=0, n=16: M tlast=1 on this beat. Go to ST_IDLE.
    - enc=0, n<16: M tlast=0 on this beat. Pulse Err for 1 cycle, set pad_val=0, go to ST_PAD.
  - ST_PAD: S tready=0; emits bytes of value pad_val until byte_cnt wraps. The beat with byte_cnt==15 carries tlast=1. Then go to ST_IDLE.
- Handshake rules:
  - M_axis tdata, tlast and tuser are held stable while tvalid=1 and tready=0.
  - tvalid is never deasserted without a handshake in ST_KEY_0, ST_KEY_1, ST_IV and ST_PAD.
- Counting rules:
  - Total output bytes per message = 48 + 16*ceil(payload/16), plus 16 extra when enc=1 and payload is a multiple of 16.
  - byte_cnt resets to 0 on entry to ST_KEY_0.
- Simultaneous events:
  - Cfg_valid asserted outside ST_IDLE is ignored (Cfg_ready=0).
  - S_axis data presented in the header states is stalled, not dropped.
- Latency: first M beat is valid the cycle after the Cfg handshake.

Test Plan:
- Encrypt, 16-byte payload 0x00..0x0F:
  - Output is 48 header bytes, then 0x00..0x0F, then 16 bytes of 0x10.
  - tlast only on beat 80; tuser=1 on all beats.
- Encrypt, 5-byte payload 0xA1..0xA5:
  - After the header: 0xA1..0xA5, then 11 bytes of 0x0B.
  - tlast on beat 64.
- Decrypt, 32-byte payload:
  - Passed unmodified after the header; tlast on beat 80; tuser=0; Err never pulses.
- Decrypt, 20-byte payload:
  - Err pulses once, on the 20th payload handshake.
  - Then 12 bytes of 0x00; tlast on beat 80.
- Randomised M tready backpressure with key 0x00..0x1F and IV 0xF0..0xFF:
  - Header byte order is exactly 0x00..0x1F then 0xF0..0xFF.
  - Data stays stable during stalls.
  - Cfg_valid pulsed mid-message has no effect.
- Rst_n driven low during ST_PAD:
  - Outputs are 0 asynchronously.
  - After release, Cfg_ready=1 and a new 1-byte encrypt message yields pad 0x0F x15.
